life_phase_scheduler: RTL and testbench

Sequences the Game-of-Life board engines (init/randomise writer, neighbour-count update engine, next-to-current copy engine) through generation phases. Generations are paced in whole video frames and launched only at frame_start (vblank), so board writes never tear the display. Handshakes with each engine by start pulse / done pulse. Sits between hvsync_generator/top-level controls and the engines; replaces ad-hoc phase logic in the top module.

---
 rtl/life_pkg.sv | 26 ++
 rtl/life_frame_divider.sv | 84 ++++++++
 rtl/life_phase_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_life_phase_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life board engines and scheduler.
//
// Contents:
//   phase_e     - scheduler phase encoding (IDLE=0, UPDATE=1, COPY=2, INIT=3)
//   LOG_WIDTH   - log2 of board width in cells
//   LOG_HEIGHT  - log2 of board height in cells
//   BOARD_SIZE  - total cell count
//   phase_busy  - true for every phase other than IDLE
package life_pkg;

  localparam int unsigned LOG_WIDTH  = 5;
  localparam int unsigned LOG_HEIGHT = 4;
  localparam int unsigned BOARD_SIZE = 1 << (LOG_WIDTH + LOG_HEIGHT);

  typedef enum logic [1:0] {
    PhaseIdle   = 2'd0,
    PhaseUpdate = 2'd1,
    PhaseCopy   = 2'd2,
    PhaseInit   = 2'd3
  } phase_e;

  function automatic logic phase_busy(input phase_e p);
    return p != PhaseIdle;
  endfunction

endpackage

// File: rtl/life_frame_divider.sv
// Frame pacing for the generation scheduler. Counts frame_start pulses while
// free-running, holds a single-step request while stopped, and emits gen_tick
// on the frame_start cycle that should launch a generation.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   frame_start     - one-cycle pulse at start of vblank
//   run             - level, free-running generations
//   step            - pulse, request one generation while run=0
//   idle            - scheduler is in IDLE; frames arriving while busy are dropped
//   frames_per_gen  - frames per generation, 0 treated as 1
//   gen_tick        - one-cycle launch request (only ever asserted while idle)
module life_frame_divider #(
  parameter int unsigned FRAME_DIV_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   run,
  input  logic                   step,
  input  logic                   idle,
  input  logic [FRAME_DIV_W-1:0] frames_per_gen,
  output logic                   gen_tick
);

  logic [FRAME_DIV_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   step_pending_q, step_pending_d;
  logic                   run_q;

  // One extra bit so count+1 never wraps before the compare.
  logic [FRAME_DIV_W:0]   cnt_inc;
  logic [FRAME_DIV_W:0]   div_eff;
  logic                   div_reached;

  always_comb begin
    cnt_inc     = {1'b0, frame_cnt_q} + 1'b1;
    div_eff     = (frames_per_gen == '0) ? {{FRAME_DIV_W{1'b0}}, 1'b1}
                                         : {1'b0, frames_per_gen};
    // Compared live, so lowering frames_per_gen below the count launches on
    // the very next frame.
    div_reached = cnt_inc >= div_eff;
  end

  always_comb begin
    gen_tick       = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    step_pending_d = step_pending_q;

    if (!run) begin
      frame_cnt_d = '0;
      if (idle && frame_start && step_pending_q) begin
        gen_tick       = 1'b1;
        step_pending_d = 1'b0;
      end else if (idle && step) begin
        step_pending_d = 1'b1;
      end
    end else begin
      if (!run_q) begin
        step_pending_d = 1'b0;
      end
      if (idle && frame_start) begin
        if (div_reached) begin
          gen_tick    = 1'b1;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = cnt_inc[FRAME_DIV_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q    <= '0;
      step_pending_q <= 1'b0;
      run_q          <= 1'b0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      step_pending_q <= step_pending_d;
      run_q          <= run;
    end
  end

endmodule

// File: rtl/life_phase_scheduler.sv
// Generation phase scheduler for the Game-of-Life engines. Launches generations
// only on frame_start (vblank) via life_frame_divider, then walks
// UPDATE -> COPY -> IDLE, or INIT -> IDLE for randomisation, using one-cycle
// start/done handshakes with each engine. A watchdog aborts a phase that never
// completes and raises a sticky timeout_err.
//
// Optional build macro LIFE_AUTO_RESEED_EN: adds input copy_changed and a stall
// counter; after STALL_LIMIT consecutive generations with no cell change the
// next launch is forced to INIT.
//
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   frame_start, run, step          - pacing controls (see life_frame_divider)
//   randomize                       - sampled at launch: 1 = INIT instead of UPDATE
//   frames_per_gen                  - frames per generation, 0 treated as 1
//   init_start/upd_start/copy_start - one-cycle engine start pulses
//   init_done/upd_done/copy_done    - one-cycle engine completion pulses
//   copy_changed                    - (LIFE_AUTO_RESEED_EN) valid with copy_done
//   phase                           - IDLE=0, UPDATE=1, COPY=2, INIT=3
//   busy                            - phase != IDLE
//   gen_count                       - completed generations since last INIT
//   timeout_err                     - sticky watchdog flag
module life_phase_scheduler
  import life_pkg::*;
#(
  parameter int unsigned FRAME_DIV_W = 4,
  parameter int unsigned GEN_W       = 16,
`ifdef LIFE_AUTO_RESEED_EN
  parameter int unsigned STALL_LIMIT = 8,
`endif
  parameter int unsigned TIMEOUT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   run,
  input  logic                   step,
  input  logic                   randomize,
  input  logic [FRAME_DIV_W-1:0] frames_per_gen,
  input  logic                   init_done,
  input  logic                   upd_done,
  input  logic                   copy_done,
`ifdef LIFE_AUTO_RESEED_EN
  input  logic                   copy_changed,
`endif
  output logic                   init_start,
  output logic                   upd_start,
  output logic                   copy_start,
  output logic [1:0]             phase,
  output logic                   busy,
  output logic [GEN_W-1:0]       gen_count,
  output logic                   timeout_err
);

  // Abort fires during the (2^TIMEOUT_W-1)th busy cycle of a phase.
  localparam logic [TIMEOUT_W-1:0] WdLast = {TIMEOUT_W{1'b1}} - 1'b1;

  phase_e               phase_q, phase_d;
  logic                 entry_q, entry_d;
  logic [GEN_W-1:0]     gen_q, gen_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q, timeout_d;
  logic                 leave;
  logic                 gen_tick;
  logic                 force_init;
  logic                 is_idle;

  assign is_idle = (phase_q == PhaseIdle);

  life_frame_divider #(
    .FRAME_DIV_W (FRAME_DIV_W)
  ) u_frame_divider (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .run            (run),
    .step           (step),
    .idle           (is_idle),
    .frames_per_gen (frames_per_gen),
    .gen_tick       (gen_tick)
  );

`ifdef LIFE_AUTO_RESEED_EN
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_LIMIT);

  logic [StallW-1:0] stall_q, stall_d;

  assign force_init = (stall_q >= StallMax);

  always_comb begin
    stall_d = stall_q;
    if (phase_q == PhaseCopy && copy_done && !entry_q) begin
      if (copy_changed) begin
        stall_d = '0;
      end else if (stall_q != StallMax) begin
        stall_d = stall_q + 1'b1;
      end
    end
    if (phase_q == PhaseInit && init_done && !entry_q) begin
      stall_d = '0;
    end
    if (is_idle && gen_tick && force_init) begin
      stall_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign force_init = 1'b0;
`endif

  always_comb begin
    phase_d   = phase_q;
    entry_d   = 1'b0;
    gen_d     = gen_q;
    timeout_d = timeout_q;
    leave     = 1'b0;

    // Done on the entry cycle is ignored: it cannot belong to this start.
    unique case (phase_q)
      PhaseIdle: begin
        if (gen_tick) begin
          phase_d = (randomize || force_init) ? PhaseInit : PhaseUpdate;
          entry_d = 1'b1;
        end
      end
      PhaseUpdate: begin
        if (upd_done && !entry_q) begin
          phase_d = PhaseCopy;
          entry_d = 1'b1;
          leave   = 1'b1;
        end
      end
      PhaseCopy: begin
        if (copy_done && !entry_q) begin
          phase_d = PhaseIdle;
          gen_d   = gen_q + 1'b1;
          leave   = 1'b1;
        end
      end
      PhaseInit: begin
        if (init_done && !entry_q) begin
          phase_d = PhaseIdle;
          gen_d   = '0;
          leave   = 1'b1;
        end
      end
      default: ;
    endcase

    if (!is_idle && !leave && wd_q == WdLast) begin
      phase_d   = PhaseIdle;
      timeout_d = 1'b1;
    end

    if (entry_d || phase_d == PhaseIdle) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Boot randomisation: INIT with a pending start pulse.
      phase_q   <= PhaseInit;
      entry_q   <= 1'b1;
      gen_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      entry_q   <= entry_d;
      gen_q     <= gen_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // Gated by reset so no engine sees a start while the scheduler is held.
  assign init_start  = entry_q && !reset && (phase_q == PhaseInit);
  assign upd_start   = entry_q && !reset && (phase_q == PhaseUpdate);
  assign copy_start  = entry_q && !reset && (phase_q == PhaseCopy);
  assign phase       = phase_q;
  assign busy        = phase_busy(phase_q);
  assign gen_count   = gen_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_life_phase_scheduler.sv
// Directed testbench for life_phase_scheduler. A simple engine model answers
// each start pulse with a done pulse eng_lat cycles later (or never, when
// eng_en=0). Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_life_phase_scheduler;

  localparam int unsigned FDW = 4;
  localparam int unsigned GW  = 2;
  localparam int unsigned TW  = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_start;
  logic           run;
  logic           step;
  logic           randomize;
  logic [FDW-1:0] frames_per_gen;
  logic           init_done;
  logic           upd_done;
  logic           copy_done;
`ifdef LIFE_AUTO_RESEED_EN
  logic           copy_changed;
`endif
  logic           init_start;
  logic           upd_start;
  logic           copy_start;
  logic [1:0]     phase;
  logic           busy;
  logic [GW-1:0]  gen_count;
  logic           timeout_err;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_init = 0;
  int n_upd  = 0;
  int n_copy = 0;
  bit eng_en  = 1'b1;
  int eng_lat = 10;

  always #5 clk = ~clk;

  life_phase_scheduler #(
    .FRAME_DIV_W (FDW),
    .GEN_W       (GW),
`ifdef LIFE_AUTO_RESEED_EN
    .STALL_LIMIT (2),
`endif
    .TIMEOUT_W   (TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .run            (run),
    .step           (step),
    .randomize      (randomize),
    .frames_per_gen (frames_per_gen),
    .init_done      (init_done),
    .upd_done       (upd_done),
    .copy_done      (copy_done),
`ifdef LIFE_AUTO_RESEED_EN
    .copy_changed   (copy_changed),
`endif
    .init_start     (init_start),
    .upd_start      (upd_start),
    .copy_start     (copy_start),
    .phase          (phase),
    .busy           (busy),
    .gen_count      (gen_count),
    .timeout_err    (timeout_err)
  );

  // Engine model: done pulses eng_lat cycles after the start cycle.
  initial begin : engine
    int ci;
    int cu;
    int cc;
    ci = 0;
    cu = 0;
    cc = 0;
    init_done = 1'b0;
    upd_done  = 1'b0;
    copy_done = 1'b0;
    forever begin
      @(negedge clk);
      init_done = 1'b0;
      upd_done  = 1'b0;
      copy_done = 1'b0;
      if (init_start) n_init++;
      if (upd_start)  n_upd++;
      if (copy_start) n_copy++;
      if (reset || !eng_en) begin
        ci = 0;
        cu = 0;
        cc = 0;
      end else begin
        if (init_start) ci = eng_lat;
        else if (ci > 0) begin ci--; if (ci == 0) init_done = 1'b1; end
        if (upd_start) cu = eng_lat;
        else if (cu > 0) begin cu--; if (cu == 0) upd_done = 1'b1; end
        if (copy_start) cc = eng_lat;
        else if (cc > 0) begin cc--; if (cc == 0) copy_done = 1'b1; end
      end
    end
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t required < 200000",
             $time);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    next_cyc();
    frame_start = 1'b0;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    next_cyc();
    step = 1'b0;
  endtask

  initial begin : main
    reset          = 1'b1;
    frame_start    = 1'b0;
    run            = 1'b0;
    step           = 1'b0;
    randomize      = 1'b0;
    frames_per_gen = 4'd3;
`ifdef LIFE_AUTO_RESEED_EN
    copy_changed   = 1'b1;
`endif

    // Reset state and boot INIT.
    next_cyc(3);
    @(negedge clk);
    check_val("rst_phase", phase, 2'd3);
    check_val("rst_init_start", init_start, 1'b0);
    check_val("rst_upd_start", upd_start, 1'b0);
    check_val("rst_gen", gen_count, 0);
    check_val("rst_timeout", timeout_err, 1'b0);
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    check_val("boot_init_start", init_start, 1'b1);
    check_val("boot_busy", busy, 1'b1);
    next_cyc();
    @(negedge clk);
    check_val("boot_init_pulse_width", init_start, 1'b0);
    next_cyc(9);
    @(negedge clk);
    check_val("boot_init_wait", phase, 2'd3);
    next_cyc();
    @(negedge clk);
    check_val("boot_idle", phase, 2'd0);
    check_val("boot_gen", gen_count, 0);
    check_val("boot_busy_low", busy, 1'b0);

    // Free-running, frames_per_gen=3.
    eng_lat = 8;
    next_cyc();
    run = 1'b1;
    next_cyc(2);
    frame();
    @(negedge clk);
    check_val("fpg3_frame1", phase, 2'd0);
    next_cyc(5);
    frame();
    @(negedge clk);
    check_val("fpg3_frame2", phase, 2'd0);
    next_cyc(5);
    frame();
    @(negedge clk);
    check_val("fpg3_launch", upd_start, 1'b1);
    check_val("fpg3_launch_phase", phase, 2'd1);
    next_cyc(9);
    @(negedge clk);
    check_val("copy_after_upd", copy_start, 1'b1);
    check_val("copy_phase", phase, 2'd2);
    next_cyc(12);
    @(negedge clk);
    check_val("gen_after_first", gen_count, 1);
    check_val("idle_after_first", phase, 2'd0);
    next_cyc();
    frame();
    next_cyc(3);
    frame();
    next_cyc(3);
    frame();
    @(negedge clk);
    check_val("fpg3_second_launch", upd_start, 1'b1);
    next_cyc(25);
    @(negedge clk);
    check_val("gen_after_second", gen_count, 2);
    check_val("upd_count_fpg3", n_upd, 2);
    check_val("copy_count_fpg3", n_copy, 2);

    // frames_per_gen=0: every frame launches; frames while busy are dropped.
    next_cyc();
    frames_per_gen = 4'd0;
    frame();
    @(negedge clk);
    check_val("fpg0_launch", phase, 2'd1);
    next_cyc(2);
    frame();
    next_cyc(25);
    @(negedge clk);
    check_val("fpg0_drop_busy_frame", n_upd, 3);
    check_val("gen_3", gen_count, 3);
    next_cyc();
    frame();
    next_cyc(25);
    @(negedge clk);
    check_val("gen_wrap", gen_count, 0);

    // Live frames_per_gen change below the current count.
    next_cyc();
    frames_per_gen = 4'd4;
    frame();
    next_cyc(2);
    frame();
    @(negedge clk);
    check_val("fpg4_hold", phase, 2'd0);
    next_cyc();
    frames_per_gen = 4'd2;
    frame();
    @(negedge clk);
    check_val("fpg_live_change", phase, 2'd1);
    next_cyc(25);
    @(negedge clk);
    check_val("gen_after_change", gen_count, 1);

    // Single step while stopped.
    next_cyc();
    run = 1'b0;
    next_cyc(2);
    step_pulse();
    next_cyc(2);
    frame();
    @(negedge clk);
    check_val("step_launch", phase, 2'd1);
    next_cyc(25);
    frame();
    @(negedge clk);
    check_val("step_once", phase, 2'd0);
    check_val("step_gen", gen_count, 2);
    check_val("step_upd_count", n_upd, 6);

    // A rising run clears a pending step.
    next_cyc();
    step_pulse();
    next_cyc();
    run = 1'b1;
    next_cyc();
    run = 1'b0;
    next_cyc();
    frame();
    @(negedge clk);
    check_val("run_rise_clears_step", phase, 2'd0);

    // Step while busy is ignored.
    next_cyc();
    step_pulse();
    frame();
    @(negedge clk);
    check_val("step2_launch", phase, 2'd1);
    next_cyc(2);
    step_pulse();
    next_cyc(25);
    frame();
    @(negedge clk);
    check_val("step_busy_ignored", phase, 2'd0);
    check_val("gen_after_step2", gen_count, 3);

    // randomize=1 at launch selects INIT and clears gen_count.
    next_cyc();
    randomize = 1'b1;
    step_pulse();
    frame();
    @(negedge clk);
    check_val("rand_init_start", init_start, 1'b1);
    check_val("rand_phase", phase, 2'd3);
    next_cyc();
    randomize = 1'b0;
    next_cyc(25);
    @(negedge clk);
    check_val("rand_gen_clear", gen_count, 0);
    check_val("rand_idle", phase, 2'd0);

    // Watchdog: upd_done withheld, abort in the 63rd busy cycle.
    next_cyc();
    eng_en = 1'b0;
    step_pulse();
    frame();
    @(negedge clk);
    check_val("wd_launch", phase, 2'd1);
    next_cyc(62);
    @(negedge clk);
    check_val("wd_before_phase", phase, 2'd1);
    check_val("wd_before_flag", timeout_err, 1'b0);
    next_cyc();
    @(negedge clk);
    check_val("wd_abort_phase", phase, 2'd0);
    check_val("wd_abort_flag", timeout_err, 1'b1);
    check_val("wd_gen_keep", gen_count, 0);
    next_cyc();
    eng_en = 1'b1;
    step_pulse();
    frame();
    next_cyc(25);
    @(negedge clk);
    check_val("gen_after_wd", gen_count, 1);
    check_val("wd_sticky", timeout_err, 1'b1);

    // Reset mid-phase aborts and re-enters INIT.
    next_cyc();
    step_pulse();
    frame();
    next_cyc(3);
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    check_val("midreset_init_start", init_start, 1'b1);
    check_val("midreset_phase", phase, 2'd3);
    check_val("reset_clears_timeout", timeout_err, 1'b0);
    check_val("midreset_gen", gen_count, 0);
    next_cyc(15);
    @(negedge clk);
    check_val("midreset_idle", phase, 2'd0);

`ifdef LIFE_AUTO_RESEED_EN
    // Two unchanged generations force the next launch to INIT.
    next_cyc();
    copy_changed = 1'b0;
    randomize    = 1'b0;
    repeat (2) begin
      step_pulse();
      frame();
      next_cyc(25);
    end
    @(negedge clk);
    check_val("stall_gens", gen_count, 2);
    next_cyc();
    step_pulse();
    frame();
    @(negedge clk);
    check_val("stall_reseed", init_start, 1'b1);
    next_cyc(25);
    @(negedge clk);
    check_val("stall_gen_clear", gen_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
